// File: rtl/bnn_layer_sequencer_if.sv
// Handshake, configuration and comparator-control bundle of the BNN layer sequencer.
// The sequencer binds to the slave modport; its environment drives through master.
`timescale 1ns/1ps
interface bnn_layer_sequencer_if #(
  parameter int IL = 10
);
  logic          iSTART;
  logic          iCLR;
  logic          iCFG_WE;
  logic [1:0]    iCFG_ADDR;
  logic [IL-1:0] iCFG_DATA;
  logic          iMAC_VALID;
  logic          oMAC_READY;
  logic          iCMP_OEN;
  logic [2:0]    oSTATE;
  logic [1:0]    oPAD;
  logic [IL-1:0] oTH;
  logic          oCMP_EN;
  logic          oBUSY;
  logic          oDONE;
  logic          oERR;

  modport master (
    output iSTART, iCLR, iCFG_WE, iCFG_ADDR, iCFG_DATA, iMAC_VALID, iCMP_OEN,
    input  oMAC_READY, oSTATE, oPAD, oTH, oCMP_EN, oBUSY, oDONE, oERR
  );

  modport slave (
    input  iSTART, iCLR, iCFG_WE, iCFG_ADDR, iCFG_DATA, iMAC_VALID, iCMP_OEN,
    output oMAC_READY, oSTATE, oPAD, oTH, oCMP_EN, oBUSY, oDONE, oERR
  );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Walks the threshold comparator through L1 (padded), L2, L3 and optionally FC.
// Define SEQ_FC_EN to sequence the fully connected layer; otherwise L3 ends the frame.
`timescale 1ns/1ps
module bnn_layer_sequencer #(
  parameter int IL = 10,
  parameter int W1 = 16,
  parameter int N1 = 256,
  parameter int N2 = 128,
  parameter int N3 = 64,
  parameter int N4 = 10,
  parameter int CW = 16
) (
  input logic iCLK,
  input logic iRSTn,
  bnn_layer_sequencer_if.slave bus
);
  localparam int CLW = $clog2(W1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(W1 - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b000, L1 = 3'b010, L2 = 3'b011, L3 = 3'b100, FC = 3'b101, FIN = 3'b110
  } state_t;

  state_t                state_r, nextState_s;
  logic [CW-1:0]         issued_r, returned_r, issuedNext_s, returnedNext_s, nLayer_s;
  logic [CLW-1:0]        col_r, colNext_s;
  logic                  err_r, errNext_s;
  logic signed [IL-1:0]  table_r [4];
  logic signed [IL-1:0]  th_r, thNext_s;
  logic                  ready_s, cmpEn_s, spurious_s, retOk_s, fcAddr_s, wrEn_s, wrErr_s;
  logic [1:0]            pad_s, nextIdx_s;

  function automatic logic isLayer(input state_t s);
    case (s)
      L1, L2, L3, FC: isLayer = 1'b1;
      default:        isLayer = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] layerIdx(input state_t s);
    case (s)
      L2:      layerIdx = 2'd1;
      L3:      layerIdx = 2'd2;
      FC:      layerIdx = 2'd3;
      default: layerIdx = 2'd0;
    endcase
  endfunction

  function automatic logic [CW-1:0] layerSize(input state_t s);
    case (s)
      L1:      layerSize = CW'(N1);
      L2:      layerSize = CW'(N2);
      L3:      layerSize = CW'(N3);
      FC:      layerSize = CW'(N4);
      default: layerSize = {CW{1'b0}};
    endcase
  endfunction

  // Handshake, return bookkeeping and configuration-write qualification.
  always_comb begin
    nLayer_s    = layerSize(state_r);
    ready_s     = isLayer(state_r) && (issued_r < nLayer_s);
    cmpEn_s     = bus.iMAC_VALID && ready_s;
    spurious_s  = bus.iCMP_OEN && (returned_r == issued_r);
    retOk_s     = bus.iCMP_OEN && !spurious_s;
`ifdef SEQ_FC_EN
    fcAddr_s    = 1'b0;
`else
    fcAddr_s    = (bus.iCFG_ADDR == 2'd3);
`endif
    wrEn_s      = bus.iCFG_WE && !fcAddr_s && !bus.iCLR && (state_r == IDLE);
    wrErr_s     = bus.iCFG_WE && !fcAddr_s && (state_r != IDLE);
  end

  // Next-state, counter, column and error update.
  always_comb begin
    nextState_s    = state_r;
    issuedNext_s   = issued_r + CW'(cmpEn_s);
    returnedNext_s = returned_r + CW'(retOk_s);
    colNext_s      = col_r;
    errNext_s      = err_r | spurious_s | wrErr_s;
    if ((state_r == L1) && cmpEn_s) begin
      colNext_s = (col_r == COL_LAST) ? {CLW{1'b0}} : col_r + CLW'(1);
    end else begin
      colNext_s = col_r;
    end
    case (state_r)
      IDLE: begin
        issuedNext_s   = {CW{1'b0}};
        returnedNext_s = {CW{1'b0}};
        colNext_s      = {CLW{1'b0}};
        if (bus.iSTART) begin
          nextState_s = L1;
          errNext_s   = spurious_s | wrErr_s;
        end else begin
          nextState_s = IDLE;
        end
      end
      L1, L2, L3, FC: begin
        if (returned_r == nLayer_s) begin
          issuedNext_s   = {CW{1'b0}};
          returnedNext_s = {CW{1'b0}};
          colNext_s      = {CLW{1'b0}};
          case (state_r)
            L1:      nextState_s = L2;
            L2:      nextState_s = L3;
`ifdef SEQ_FC_EN
            L3:      nextState_s = FC;
`else
            L3:      nextState_s = FIN;
`endif
            default: nextState_s = FIN;
          endcase
        end else begin
          nextState_s = state_r;
        end
      end
      FIN:     nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
    if (bus.iCLR) begin
      nextState_s    = IDLE;
      issuedNext_s   = {CW{1'b0}};
      returnedNext_s = {CW{1'b0}};
      colNext_s      = {CLW{1'b0}};
      errNext_s      = 1'b0;
    end else begin
      errNext_s = errNext_s;
    end
    // A write in the start cycle must already show on the threshold at L1 entry.
    nextIdx_s = layerIdx(nextState_s);
    if (!isLayer(nextState_s)) begin
      thNext_s = {IL{1'b0}};
    end else if (wrEn_s && (bus.iCFG_ADDR == nextIdx_s)) begin
      thNext_s = bus.iCFG_DATA;
    end else begin
      thNext_s = table_r[nextIdx_s];
    end
  end

  // FSM state, counters, column, threshold output and sticky error.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_r    <= IDLE;
      issued_r   <= {CW{1'b0}};
      returned_r <= {CW{1'b0}};
      col_r      <= {CLW{1'b0}};
      th_r       <= {IL{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      issued_r   <= issuedNext_s;
      returned_r <= returnedNext_s;
      col_r      <= colNext_s;
      th_r       <= thNext_s;
      err_r      <= errNext_s;
    end
  end

  // Threshold table; survives the soft clear.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int i = 0; i < 4; i++) table_r[i] <= {IL{1'b0}};
    end else if (wrEn_s) begin
      table_r[bus.iCFG_ADDR] <= bus.iCFG_DATA;
    end
  end

  // Edge padding is only meaningful while layer 1 streams.
  always_comb begin
    pad_s = 2'd0;
    if (state_r == L1) begin
      if (col_r == {CLW{1'b0}})  pad_s = 2'd1;
      else if (col_r == COL_LAST) pad_s = 2'd2;
      else                        pad_s = 2'd0;
    end else begin
      pad_s = 2'd0;
    end
  end

  assign bus.oSTATE     = state_r;
  assign bus.oPAD       = pad_s;
  assign bus.oTH        = th_r;
  assign bus.oMAC_READY = ready_s;
  assign bus.oCMP_EN    = cmpEn_s;
  assign bus.oBUSY      = (state_r != IDLE);
  assign bus.oDONE      = (state_r == FIN);
  assign bus.oERR       = err_r;
endmodule

// File: doc/bnn_layer_sequencer.md
# bnn_layer_sequencer

Controller for the threshold comparator of the binarized inference datapath. Holds a per-layer signed threshold table and walks the comparator through the layer sequence: conv layer 1 with edge-dependent padding mode, conv layers 2 and 3, then the fully connected layer. It gates accumulator results into the comparator with a valid/ready handshake and counts the comparator's returned enables. It advances to the next layer only when every result of the current layer has drained.

## Interface
- IL, 10: threshold/data width; must match the comparator.
- W1, 16: layer-1 output columns per row; must be ≥2.
- N1, 256: layer-1 outputs; must be a multiple of W1.
- N2, 128: layer-2 outputs.
- N3, 64: layer-3 outputs.
- N4, 10: FC outputs.
- CW, 16: issue/return counter width; each of N1..N4 must be < 2^CW.

- iCLK in 1: clock, rising edge.
- iRSTn in 1: asynchronous active-low reset.
- iSTART in 1: start a frame; honoured only in IDLE.
- iCLR in 1: synchronous soft clear to IDLE; thresholds kept.
- iCFG_WE in 1: threshold write strobe.
- iCFG_ADDR in 2: threshold index (0=L1, 1=L2, 2=L3, 3=FC).
- iCFG_DATA in IL: signed threshold value.
- iMAC_VALID in 1: accumulator result present at comparator data input.
- oMAC_READY out 1: controller accepts a result this cycle.
- iCMP_OEN in 1: comparator output-valid (its enable delayed one cycle).
- oSTATE out 3: comparator layer code.
- oPAD out 2: comparator padding code.
- oTH out IL: signed threshold for the current layer.
- oCMP_EN out 1: comparator sample enable; equals iMAC_VALID & oMAC_READY.
- oBUSY out 1: high in any state other than IDLE.
- oDONE out 1: one-cycle frame-complete pulse.
- oERR out 1: sticky protocol error.

## Operation
- FSM states double as oSTATE codes: IDLE=000, L1=010, L2=011, L3=100, FC=101, FIN=110.
- IDLE: iSTART → L1. Clear both counters and oERR.
- In L1..FC: oMAC_READY = (issued < N_layer). Each oCMP_EN cycle increments issued. Each iCMP_OEN increments returned. Both may increment in the same cycle.
- The layer ends when returned == N_layer. Transitions: L1→L2→L3→FC→FIN. On each transition, clear issued and returned.
- FIN: oDONE=1 for that cycle, then → IDLE.
- Padding applies in L1 only. Column counter col increments on each issue and wraps W1-1→0.
  - oPAD=1 when col==0.
  - oPAD=2 when col==W1-1.
  - oPAD=0 otherwise.
  - Outside L1, oPAD=0.
- oTH = table[layer index] in L1..FC; oTH=0 in IDLE and FIN.
- Threshold writes:
  - Accepted only in IDLE, including the cycle iSTART is high; the write lands before L1 begins.
  - Writes in any other state are ignored and set oERR.
- oERR also sets on iCMP_OEN when returned == issued (nothing outstanding). That return is not counted.
- iMAC_VALID while oMAC_READY=0 is not an error; upstream holds its data.
- iCLR has priority over everything except reset: → IDLE, counters/col zeroed, oERR cleared, table kept.

## Timing
- Reset values: state IDLE, oSTATE=000, oPAD=0, oTH=0, oMAC_READY=0, oCMP_EN=0, oBUSY=0, oDONE=0, oERR=0, table all 0.
- oSTATE, oTH and the counters are registered. oPAD is decoded from registered col. oMAC_READY and oCMP_EN are combinational from registers and iMAC_VALID.
- iSTART at edge t → oSTATE=010, oMAC_READY=1 after t.
- The comparator returns iCMP_OEN one cycle after oCMP_EN. With continuous iMAC_VALID, layer k ends N_k+1 cycles after entry; the next layer's state appears one cycle later. This gives a 2-cycle ready bubble per layer boundary.
- oDONE is high in the cycle oSTATE=110.

## Configuration
- SEQ_FC_EN defined: FC layer sequenced as above.
- SEQ_FC_EN undefined:
  - L3 goes directly to FIN.
  - Writes to address 3 are silently ignored and do not set oERR.
  - Code 101 is never output.

## Test plan
Use W1=4, N1=8, N2=3, N3=2, N4=2.
- Reset, then write thresholds 5, -3, 100, 7 in IDLE. Start with iMAC_VALID held high and ideal 1-cycle iCMP_OEN. Expected: oSTATE 010/011/100/101/110 with oTH 5/-3/100/7/0, and a single oDONE pulse.
- L1 padding: over 8 issues, oPAD sequence must be 1,0,0,2,1,0,0,2.
- Backpressure: iMAC_VALID toggling 1/0 in L2. Expected: exactly 3 oCMP_EN pulses, and oMAC_READY low after the 3rd until the state changes to 100.
- Spurious iCMP_OEN in IDLE sets oERR=1 without changing state. A write during L2 sets oERR and leaves oTH unchanged. The next iSTART clears oERR.
- iCLR mid-L3 after 1 issue: next cycle oSTATE=000, oBUSY=0. A new iSTART re-runs from L1 with the previously loaded thresholds.
- Build without SEQ_FC_EN: the sequence ends 100→110, and a write to address 3 leaves oERR=0.
